// File: rtl/dar_prgrm_tx.sv
// Serial program-port initiator: serializes a command word MSB first under an
// active-low frame strobe, watches the receiver's err_ line and retries rejected frames.
module dar_prgrm_tx #(
    parameter int CMD_W     = 6,
    parameter int GAP_CYC   = 2,
    parameter int ERR_WIN   = 3,
    parameter int MAX_RETRY = 1
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             cmd_valid,
    input  logic [CMD_W-1:0] cmd_data,
    output logic             cmd_ready,
    output logic             prgrm_in,
    output logic             prgrm_go_,
    input  logic             err_,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic             busy
);

    localparam int CNT_W   = 8;
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SHIFT = 3'd1;
    localparam logic [2:0] GAP   = 3'd2;
    localparam logic [2:0] CHECK = 3'd3;
    localparam logic [2:0] RESP  = 3'd4;

    logic [2:0]         state_r;
    logic [2:0]         state_nx_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CMD_W-1:0]   shift_r;
    logic [CMD_W-1:0]   copy_r;
    logic [RETRY_W-1:0] retry_r;
    logic               rej_r;
    logic               rej_now_s;
    logic               accept_s;
    logic               retry_s;
    logic               prgrm_in_r;
    logic               prgrm_go_r;
    logic               cmd_ready_r;
    logic               rsp_valid_r;
    logic               rsp_err_r;
    logic               busy_r;

    assign accept_s  = cmd_valid && cmd_ready_r && (state_r == IDLE);
    // Rejection seen so far in this window, including the sample taken this cycle.
    assign rej_now_s = rej_r || !err_;

    // Next-state decode; retry_s marks a rejected frame that will be resent.
    always_comb begin
        state_nx_s = state_r;
        retry_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nx_s = SHIFT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == CNT_W'(CMD_W - 1)) begin
                    state_nx_s = GAP;
                end else begin
                    state_nx_s = SHIFT;
                end
            end
            GAP: begin
                if (cnt_r == CNT_W'(GAP_CYC - 1)) begin
                    state_nx_s = CHECK;
                end else begin
                    state_nx_s = GAP;
                end
            end
            CHECK: begin
                if (cnt_r == CNT_W'(ERR_WIN - 1)) begin
                    if (rej_now_s && (retry_r < RETRY_W'(MAX_RETRY))) begin
                        retry_s    = 1'b1;
                        state_nx_s = SHIFT;
                    end else begin
                        state_nx_s = RESP;
                    end
                end else begin
                    state_nx_s = CHECK;
                end
            end
            RESP: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // FSM state, phase counter, retry count and rejection flag.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            retry_r <= {RETRY_W{1'b0}};
            rej_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if ((state_nx_s == state_r) && (state_r != IDLE)) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
            if (accept_s) begin
                retry_r <= {RETRY_W{1'b0}};
            end else if (retry_s) begin
                retry_r <= retry_r + RETRY_W'(1);
            end
            if (accept_s || retry_s) begin
                rej_r <= 1'b0;
            end else if (state_r == CHECK) begin
                rej_r <= rej_now_s;
            end
        end
    end

    // Command shift register and the pristine copy used for retransmission.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            shift_r <= {CMD_W{1'b0}};
            copy_r  <= {CMD_W{1'b0}};
        end else begin
            if (accept_s) begin
                shift_r <= cmd_data;
                copy_r  <= cmd_data;
            end else if (retry_s) begin
                shift_r <= copy_r;
            end else if (state_r == SHIFT) begin
                shift_r <= {shift_r[CMD_W-2:0], 1'b0};
            end
        end
    end

    // Registered outputs; pin activity trails the internal state by one cycle.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            prgrm_go_r  <= 1'b1;
            prgrm_in_r  <= 1'b0;
            cmd_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            prgrm_go_r  <= (state_r != SHIFT);
            prgrm_in_r  <= (state_r == SHIFT) ? shift_r[CMD_W-1] : 1'b0;
            cmd_ready_r <= (state_r == IDLE) && !accept_s;
            rsp_valid_r <= (state_r == RESP);
            rsp_err_r   <= (state_r == RESP) ? rej_r : 1'b0;
            busy_r      <= (state_nx_s != IDLE);
        end
    end

    assign prgrm_go_ = prgrm_go_r;
    assign prgrm_in  = prgrm_in_r;
    assign cmd_ready = cmd_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_dar_prgrm_tx.sv
// Directed bench for dar_prgrm_tx: frame shape, retry handling, reset abort,
// ignored commands while busy and spacing of back-to-back frames.
module tb_dar_prgrm_tx;

    localparam int CMD_W   = 6;
    localparam int GAP_CYC = 2;
    localparam int ERR_WIN = 3;

    logic       clk       = 1'b0;
    logic       rst_      = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [5:0] cmd_data  = 6'd0;
    logic       err_      = 1'b1;
    logic       cmd_ready;
    logic       prgrm_in;
    logic       prgrm_go_;
    logic       rsp_valid;
    logic       rsp_err;
    logic       busy;

    int   n_chk        = 0;
    int   n_fail       = 0;
    int   cyc          = 0;
    int   frames       = 0;
    int   hi_run       = 0;
    int   gap_at_start = 0;
    int   rsp_cyc      = 0;
    int   rsp_count    = 0;
    int   rsp_before   = 0;
    logic prev_go      = 1'b1;
    logic rsp_seen     = 1'b0;
    logic rsp_e        = 1'b0;
    logic bits_q[$];

    always #5 clk = ~clk;

    dar_prgrm_tx #(
        .CMD_W     (CMD_W),
        .GAP_CYC   (GAP_CYC),
        .ERR_WIN   (ERR_WIN),
        .MAX_RETRY (1)
    ) dut (
        .clk       (clk),
        .rst_      (rst_),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .prgrm_in  (prgrm_in),
        .prgrm_go_ (prgrm_go_),
        .err_      (err_),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack_bits();
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < bits_q.size(); i++) begin
            v = {v[30:0], bits_q[i]};
        end
        return v;
    endfunction

    // One clock; samples the pins 1ns after the edge and records frame activity.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (!prgrm_go_) begin
            if (prev_go) begin
                frames++;
                gap_at_start = hi_run;
            end
            bits_q.push_back(prgrm_in);
            hi_run = 0;
        end else begin
            hi_run++;
        end
        prev_go = prgrm_go_;
        if (rsp_valid) begin
            rsp_seen = 1'b1;
            rsp_cyc  = cyc;
            rsp_e    = rsp_err;
            rsp_count++;
        end
    endtask

    // Issue one command; err_ is held low during cycles lo..hi counted from the accept edge.
    task automatic run_cmd(input logic [5:0] data, input int lo, input int hi, input bit junk);
        bits_q.delete();
        frames   = 0;
        rsp_seen = 1'b0;
        for (int i = 0; i < 20 && !cmd_ready; i++) tick();
        check_eq("ready_wait", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_data  = data;
        tick();
        cyc       = 0;
        cmd_valid = junk;
        cmd_data  = ~data;
        while (!rsp_seen && cyc < 60) begin
            err_ = !((cyc >= lo) && (cyc <= hi));
            if (junk) begin
                cmd_valid = ~cmd_valid;
                cmd_data  = cmd_valid ? 6'h2A : 6'h15;
            end
            tick();
        end
        err_      = 1'b1;
        cmd_valid = 1'b0;
        check_eq("rsp_timeout", rsp_seen, 1'b1);
    endtask

    initial begin
        #2 rst_ = 1'b0;
        repeat (3) tick();
        check_eq("rst_go", prgrm_go_, 1'b1);
        check_eq("rst_in", prgrm_in, 1'b0);
        check_eq("rst_ready", cmd_ready, 1'b0);
        check_eq("rst_rsp", rsp_valid, 1'b0);
        check_eq("rst_rsp_err", rsp_err, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        rst_ = 1'b1;
        tick();
        check_eq("ready_after_rst", cmd_ready, 1'b1);

        // Clean frame
        run_cmd(6'b100111, -1, -1, 1'b0);
        check_eq("t1_frames", frames, 32'd1);
        check_eq("t1_len", bits_q.size(), 32'd6);
        check_eq("t1_bits", pack_bits(), 32'b100111);
        check_eq("t1_lat", rsp_cyc, 32'd12);
        check_eq("t1_err", rsp_e, 1'b0);
        tick();
        check_eq("t1_ready_back", cmd_ready, 1'b1);
        check_eq("t1_busy_off", busy, 1'b0);

        // Single err_ pulse mid window: one identical retransmission
        run_cmd(6'b100111, 9, 9, 1'b0);
        check_eq("t2_frames", frames, 32'd2);
        check_eq("t2_bits", pack_bits(), 32'b100111100111);
        check_eq("t2_lat", rsp_cyc, 32'd23);
        check_eq("t2_err", rsp_e, 1'b0);

        // err_ stuck low: retries exhausted
        run_cmd(6'b100111, 0, 999, 1'b0);
        check_eq("t3_frames", frames, 32'd2);
        check_eq("t3_lat", rsp_cyc, 32'd23);
        check_eq("t3_err", rsp_e, 1'b1);
        tick();
        check_eq("t3_ready_back", cmd_ready, 1'b1);

        // err_ only during GAP is ignored
        run_cmd(6'b110001, 6, 7, 1'b0);
        check_eq("gap_frames", frames, 32'd1);
        check_eq("gap_err", rsp_e, 1'b0);
        check_eq("gap_lat", rsp_cyc, 32'd12);

        // err_ in the last sampled cycle still triggers a retry
        run_cmd(6'b110001, 10, 10, 1'b0);
        check_eq("lastwin_frames", frames, 32'd2);
        check_eq("lastwin_bits", pack_bits(), 32'b110001110001);

        // err_ during RESP is ignored
        run_cmd(6'b110001, 11, 11, 1'b0);
        check_eq("resp_err_frames", frames, 32'd1);
        check_eq("resp_err_flag", rsp_e, 1'b0);

        // New commands offered while busy are ignored
        run_cmd(6'b100111, -1, -1, 1'b1);
        check_eq("junk_frames", frames, 32'd1);
        check_eq("junk_bits", pack_bits(), 32'b100111);
        repeat (3) tick();
        check_eq("junk_no_extra", busy, 1'b0);

        // Reset during the third SHIFT cycle aborts the frame
        for (int i = 0; i < 20 && !cmd_ready; i++) tick();
        cmd_valid = 1'b1;
        cmd_data  = 6'b110011;
        tick();
        cmd_valid = 1'b0;
        repeat (3) tick();
        check_eq("abort_go_low", prgrm_go_, 1'b0);
        rsp_before = rsp_count;
        rst_ = 1'b0;
        #1;
        check_eq("abort_go_high", prgrm_go_, 1'b1);
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_ready", cmd_ready, 1'b0);
        repeat (3) tick();
        rst_ = 1'b1;
        run_cmd(6'b010101, -1, -1, 1'b0);
        check_eq("post_rst_bits", pack_bits(), 32'b010101);
        check_eq("post_rst_lat", rsp_cyc, 32'd12);
        check_eq("post_rst_rsp_cnt", rsp_count, rsp_before + 1);

        // Back-to-back frames keep the idle spacing
        run_cmd(6'h3F, -1, -1, 1'b0);
        check_eq("b2b_first_bits", pack_bits(), 32'h3F);
        run_cmd(6'h00, -1, -1, 1'b0);
        check_eq("b2b_gap", gap_at_start >= (GAP_CYC + ERR_WIN + 2), 1'b1);
        check_eq("b2b_second_frames", frames, 32'd1);
        check_eq("b2b_second_len", bits_q.size(), 32'd6);
        check_eq("b2b_second_bits", pack_bits(), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dar_prgrm_tx.md
Name: dar_prgrm_tx

Overview:
Serial programming transmitter (initiator) for the audio_app program port. It accepts a parallel command word over a valid/ready handshake and serializes it onto prgrm_in, MSB first, framed by active-low prgrm_go_. It then monitors the receiver's err_ line, retries rejected frames, and reports the result per command. It sits between the control/host logic and the audio_app program interface.

Parameters:
CMD_W, 6, bits per program frame (valid range 2..16)
GAP_CYC, 2, idle cycles with prgrm_go_=1 after each frame before err_ is sampled (≥1)
ERR_WIN, 3, cycles err_ is sampled after the gap
MAX_RETRY, 1, retransmissions allowed after a rejected frame (0 = no retry)

Ports:
clk  in  1  system clock; all logic on posedge
rst_  in  1  asynchronous active-low reset
cmd_valid  in  1  command word available
cmd_data  in  CMD_W  command word; bit CMD_W-1 is sent first
cmd_ready  out  1  block can accept a command
prgrm_in  out  1  serial program data to receiver
prgrm_go_  out  1  active-low frame strobe to receiver
err_  in  1  active-low error from receiver
rsp_valid  out  1  one-cycle pulse: command finished
rsp_err  out  1  qualified by rsp_valid; 1 = rejected after all retries
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (asynchronous on rst_=0, deasserted synchronously by design): prgrm_go_=1, prgrm_in=0, cmd_ready=0, rsp_valid=0, rsp_err=0, busy=0. The FSM enters IDLE and the retry counter clears.
- cmd_ready is 1 only in IDLE with rst_=1, from the first cycle after reset release onward.
- States: IDLE, SHIFT, GAP, CHECK, RESP.
- IDLE:
  - On cmd_valid&&cmd_ready, latch cmd_data into a shift register and an unmodified copy; go to SHIFT. The retry count is 0.
- SHIFT:
  - Lasts exactly CMD_W cycles.
  - prgrm_go_=0 and prgrm_in=current MSB, both registered outputs.
  - The first bit appears on the posedge after acceptance.
  - The register shifts left each cycle.
  - After the last bit, go to GAP.
- GAP:
  - Lasts GAP_CYC cycles with prgrm_go_=1 and prgrm_in=0.
  - err_ is ignored during GAP.
- CHECK:
  - Lasts ERR_WIN cycles; err_ is sampled each cycle.
  - If any sample is 0, the frame is marked rejected.
  - After the window, a rejected frame with retry count < MAX_RETRY increments the count, reloads the shift register from the copy, and returns to SHIFT.
  - Otherwise go to RESP.
- RESP:
  - One cycle: rsp_valid=1; rsp_err=1 if the last frame was rejected, else 0.
  - Then IDLE; cmd_ready rises the following cycle.
- Frame length is always exactly CMD_W low cycles of prgrm_go_. The block never emits a truncated frame.
- cmd_valid in non-IDLE states is ignored; cmd_data is not sampled.
- err_ low while the block is in IDLE, SHIFT or GAP is ignored; an err_ pulse confined to those states does not affect rsp_err.
- Reset mid-frame: prgrm_go_ returns to 1 immediately (asynchronously) and the frame is aborted. No rsp_valid is issued for the aborted command.
- Latency, accept to rsp_valid, no retry: 1+CMD_W+GAP_CYC+ERR_WIN cycles (default 12).
- Each retry adds CMD_W+GAP_CYC+ERR_WIN cycles.

Test Plan:
- Reset, then cmd_data=6'b100111 with cmd_valid → prgrm_go_ low for 6 cycles with prgrm_in=1,0,0,1,1,1; err_ held 1 → rsp_valid pulse with rsp_err=0, 12 cycles after accept.
- Same command, receiver drives err_=0 for one cycle in the first CHECK window, then 1 → frame retransmitted identically once; rsp_err=0.
- err_ held 0 throughout → 2 frames total (MAX_RETRY=1), then rsp_valid with rsp_err=1 and cmd_ready back to 1.
- Drive rst_=0 at the 3rd SHIFT cycle → prgrm_go_=1 in the same cycle, no rsp_valid; after release a new command 6'b010101 is serialized correctly.
- Toggle cmd_valid with new data while busy → ignored; only the first command appears on prgrm_in.
- Back-to-back commands 6'h3F then 6'h00 → at least GAP_CYC+ERR_WIN+2 cycles of prgrm_go_=1 between the two frames.
